// File: rtl/t07_simon_game.sv
`default_nettype none
// ---------------------------------------------------------------------------
// t07_simon_game : Simon-says responder; flashes an LFSR color sequence and
//                  checks the player's direction presses.   Rev 1.0
// ---------------------------------------------------------------------------
module t07_simon_game #(
  parameter int          ROUNDS      = 4,
  parameter logic [15:0] SHOW_CYCLES = 16'd50000,
  parameter logic [15:0] GAP_CYCLES  = 16'd25000,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       strobe,
  input  logic [5:0] button,
  input  logic [2:0] game_state_in,
  input  logic [2:0] playing_state_in,
  output logic [3:0] color_out,
  output logic [3:0] round_out,
  output logic       strike,
  output logic       clear_edge,
  output logic       solved,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHOW_OFF = 3'd1,
    SHOW_ON  = 3'd2,
    INPUT    = 3'd3,
    SOLVED   = 3'd4
  } state_t;

  localparam logic [15:0] GAP_LAST   = GAP_CYCLES - 16'd1;
  localparam logic [15:0] SHOW_LAST  = SHOW_CYCLES - 16'd1;
  localparam logic [3:0]  LAST_ROUND = 4'(ROUNDS);

  state_t      state, state_nxt;
  logic [15:0] lfsr;
  logic [15:0] seq, seq_nxt;
  logic        seq_valid, seq_valid_nxt;
  logic [3:0]  idx, idx_nxt;
  logic [15:0] timer, timer_nxt;
  logic [3:0]  round_nxt;
  logic [3:0]  color_nxt;
  logic        strike_nxt, clear_nxt, solved_nxt;

  logic        menu, active;
  logic        press_ok;
  logic [1:0]  press_dir;
  logic [1:0]  cur_color;
  logic [1:0]  show_color;

  assign menu      = (game_state_in == 3'd0);
  assign active    = (playing_state_in == 3'd4);
  assign cur_color = seq[{idx[2:0], 1'b0} +: 2];
  assign busy      = (state == SHOW_OFF) || (state == SHOW_ON);

  // Only a strobed, single direction button counts as a press.
  always_comb begin
    press_ok  = 1'b0;
    press_dir = 2'd0;
    case (button)
      6'b000010: begin press_ok = strobe; press_dir = 2'd0; end
      6'b000100: begin press_ok = strobe; press_dir = 2'd1; end
      6'b001000: begin press_ok = strobe; press_dir = 2'd2; end
      6'b010000: begin press_ok = strobe; press_dir = 2'd3; end
      default:   begin press_ok = 1'b0;   press_dir = 2'd0; end
    endcase
  end

  always_comb begin
    state_nxt     = state;
    seq_nxt       = seq;
    seq_valid_nxt = seq_valid;
    idx_nxt       = idx;
    timer_nxt     = timer;
    round_nxt     = round_out;
    solved_nxt    = solved;
    strike_nxt    = 1'b0;
    clear_nxt     = 1'b0;

    if (menu) begin
      state_nxt     = IDLE;
      solved_nxt    = 1'b0;
      seq_valid_nxt = 1'b0;
      round_nxt     = 4'd0;
      idx_nxt       = 4'd0;
      timer_nxt     = 16'd0;
    end else if (state != IDLE && !active) begin
      state_nxt = IDLE;
      idx_nxt   = 4'd0;
      timer_nxt = 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (active) begin
            if (!seq_valid) begin
              seq_nxt       = lfsr;
              seq_valid_nxt = 1'b1;
            end
            if (solved) begin
              state_nxt = SOLVED;
            end else begin
              state_nxt = SHOW_OFF;
              round_nxt = 4'd1;
              idx_nxt   = 4'd0;
              timer_nxt = 16'd0;
            end
          end
        end
        SHOW_OFF: begin
          if (timer == GAP_LAST) begin
            timer_nxt = 16'd0;
            if (idx < round_out) begin
              state_nxt = SHOW_ON;
            end else begin
              state_nxt = INPUT;
              idx_nxt   = 4'd0;
            end
          end else begin
            timer_nxt = timer + 16'd1;
          end
        end
        SHOW_ON: begin
          if (timer == SHOW_LAST) begin
            timer_nxt = 16'd0;
            idx_nxt   = idx + 4'd1;
            state_nxt = SHOW_OFF;
          end else begin
            timer_nxt = timer + 16'd1;
          end
        end
        INPUT: begin
          if (press_ok) begin
            if (press_dir != cur_color) begin
              strike_nxt = 1'b1;
              round_nxt  = 4'd1;
              idx_nxt    = 4'd0;
              timer_nxt  = 16'd0;
              state_nxt  = SHOW_OFF;
            end else if ((idx + 4'd1) != round_out) begin
              idx_nxt = idx + 4'd1;
            end else if (round_out != LAST_ROUND) begin
              round_nxt = round_out + 4'd1;
              idx_nxt   = 4'd0;
              timer_nxt = 16'd0;
              state_nxt = SHOW_OFF;
            end else begin
              state_nxt  = SOLVED;
              solved_nxt = 1'b1;
              clear_nxt  = 1'b1;
            end
          end
        end
        SOLVED: begin
          state_nxt = SOLVED;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    // Color register tracks the state being entered so it lines up with SHOW_ON.
    show_color = seq_nxt[{idx_nxt[2:0], 1'b0} +: 2];
    color_nxt  = (state_nxt == SHOW_ON) ? (4'b0001 << show_color) : 4'd0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      lfsr       <= SEED;
      seq        <= 16'd0;
      seq_valid  <= 1'b0;
      idx        <= 4'd0;
      timer      <= 16'd0;
      round_out  <= 4'd0;
      color_out  <= 4'd0;
      strike     <= 1'b0;
      clear_edge <= 1'b0;
      solved     <= 1'b0;
    end else begin
      state      <= state_nxt;
      lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      seq        <= seq_nxt;
      seq_valid  <= seq_valid_nxt;
      idx        <= idx_nxt;
      timer      <= timer_nxt;
      round_out  <= round_nxt;
      color_out  <= color_nxt;
      strike     <= strike_nxt;
      clear_edge <= clear_nxt;
      solved     <= solved_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_t07_simon_game.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_t07_simon_game : scoreboard bench for the Simon-says responder.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_t07_simon_game;

  localparam int          GAP  = 1;
  localparam int          SHOW = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk;
  logic       nrst;
  logic       strobe;
  logic [5:0] button;
  logic [2:0] game_state_in;
  logic [2:0] playing_state_in;
  logic [3:0] color_out;
  logic [3:0] round_out;
  logic       strike;
  logic       clear_edge;
  logic       solved;
  logic       busy;

  t07_simon_game #(
    .ROUNDS      (2),
    .SHOW_CYCLES (16'd2),
    .GAP_CYCLES  (16'd1),
    .SEED        (SEED)
  ) dut (
    .clk              (clk),
    .nrst             (nrst),
    .strobe           (strobe),
    .button           (button),
    .game_state_in    (game_state_in),
    .playing_state_in (playing_state_in),
    .color_out        (color_out),
    .round_out        (round_out),
    .strike           (strike),
    .clear_edge       (clear_edge),
    .solved           (solved),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR, same polynomial and seed as the block's generator.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge nrst) begin
    if (!nrst) m_lfsr <= SEED;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  typedef struct {
    string      tag;
    logic [11:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] dut_vec();
    return {color_out, round_out, strike, clear_edge, solved, busy};
  endfunction

  function automatic logic [3:0] col(input logic [15:0] sq, input int k);
    logic [1:0] c;
    c = sq[2*k +: 2];
    return 4'b0001 << c;
  endfunction

  function automatic logic [5:0] btn(input logic [1:0] d);
    return 6'b000010 << d;
  endfunction

  task automatic push(input string tag, input logic [3:0] c, input logic [3:0] r,
                      input logic s, input logic ce, input logic so, input logic b);
    sb_t e;
    e.tag = tag;
    e.exp = {c, r, s, ce, so, b};
    sbq.push_back(e);
  endtask

  // Full display of round r, then the first idle INPUT cycle.
  task automatic push_show(input string tag, input int r, input logic [3:0] rnd,
                           input logic [15:0] sq, input logic first_strike);
    logic s;
    s = first_strike;
    for (int k = 0; k < r; k++) begin
      for (int g = 0; g < GAP; g++) begin
        push(tag, 4'd0, rnd, s, 1'b0, 1'b0, 1'b1);
        s = 1'b0;
      end
      for (int t = 0; t < SHOW; t++) push(tag, col(sq, k), rnd, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    for (int g = 0; g < GAP; g++) begin
      push(tag, 4'd0, rnd, s, 1'b0, 1'b0, 1'b1);
      s = 1'b0;
    end
    push(tag, 4'd0, rnd, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_q();
    sb_t e;
    while (sbq.size() > 0) begin
      @(negedge clk);
      e = sbq.pop_front();
      check(e.tag, {20'd0, dut_vec()}, {20'd0, e.exp});
      strobe = 1'b0;
      button = 6'd0;
    end
  endtask

  task automatic press(input logic [5:0] b);
    strobe = 1'b1;
    button = b;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [15:0] seq_a, seq_b, seq_c;
  logic [5:0]  bad_codes [4];

  initial begin
    nrst             = 1'b0;
    strobe           = 1'b0;
    button           = 6'd0;
    game_state_in    = 3'd1;
    playing_state_in = 3'd0;
    bad_codes[0] = 6'b000001;
    bad_codes[1] = 6'b100000;
    bad_codes[2] = 6'b000110;
    bad_codes[3] = 6'b000000;

    repeat (2) @(negedge clk);
    push("reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_q();
    nrst = 1'b1;
    for (int i = 0; i < 100; i++) push("inactive", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_q();

    // First session: enter, advance, ignored codes, strike, solve.
    seq_a = m_lfsr;
    playing_state_in = 3'd4;
    push_show("a_r1", 1, 4'd1, seq_a, 1'b0);
    run_q();
    press(btn(seq_a[1:0]));
    push_show("a_r2", 2, 4'd2, seq_a, 1'b0);
    run_q();
    for (int i = 0; i < 4; i++) begin
      press(bad_codes[i]);
      push("ignored_code", 4'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      run_q();
    end
    press(btn(seq_a[1:0] + 2'd1));
    push_show("strike", 1, 4'd1, seq_a, 1'b1);
    run_q();
    press(btn(seq_a[1:0]));
    push_show("a_r2b", 2, 4'd2, seq_a, 1'b0);
    run_q();
    press(btn(seq_a[1:0]));
    push("a_idx1", 4'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    run_q();
    press(btn(seq_a[3:2]));
    push("clear_edge", 4'd0, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    push("clear_once", 4'd0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    run_q();
    for (int i = 0; i < 2; i++) begin
      press(btn(seq_a[2*i +: 2]));
      push("solved_press", 4'd0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      run_q();
    end
    playing_state_in = 3'd0;
    push("solved_deact", 4'd0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    push("solved_deact", 4'd0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    run_q();
    playing_state_in = 3'd4;
    for (int i = 0; i < 3; i++) push("solved_reenter", 4'd0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    run_q();

    // MENU clears the session; re-entry captures a fresh sequence.
    game_state_in = 3'd0;
    push("menu", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push("menu", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_q();
    game_state_in = 3'd1;
    seq_b = m_lfsr;
    push("b_gap", 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    push("b_on", col(seq_b, 0), 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    run_q();
    playing_state_in = 3'd0;
    push("show_deact", 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    push("show_deact", 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_q();
    playing_state_in = 3'd4;
    push_show("b_r1", 1, 4'd1, seq_b, 1'b0);
    run_q();
    press(btn(seq_b[1:0]));
    push_show("b_r2", 2, 4'd2, seq_b, 1'b0);
    run_q();
    press(btn(seq_b[1:0] + 2'd2));
    push("b_strike", 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    run_q();

    // Asynchronous reset mid-display.
    #3;
    nrst = 1'b0;
    #1;
    check("async_reset", {20'd0, dut_vec()}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    seq_c = m_lfsr;
    push_show("c_r1", 1, 4'd1, seq_c, 1'b0);
    run_q();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/t07_simon_game.md
# t07_simon_game

Simon-says submodule: the responder side of the playing FSM's submodule handshake. It activates when the playing state selects SIMON (3'd4), flashes a growing pseudo-random color sequence, checks the player's direction presses, and emits a one-cycle `clear_edge` pulse. That pulse drives the playing FSM's `submodule_clear_edge` input when all rounds are repeated correctly.

## Interface
- `ROUNDS`, 4: sequence length and final round; legal 1..8.
- `SHOW_CYCLES`, 16'd50000: clk cycles a color is lit; legal 1..65535.
- `GAP_CYCLES`, 16'd25000: dark clk cycles before each color and before input; legal 1..65535.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.

- `clk` input 1: clock.
- `nrst` input 1: reset, asynchronous, active-low.
- `strobe` input 1: single-cycle button-event qualifier.
- `button` input 6: one-hot button code. Bit0 SELECT, bit1 UP, bit2 RIGHT, bit3 DOWN, bit4 LEFT, bit5 BACK.
- `game_state_in` input 3: top game state; 3'd0 = MENU.
- `playing_state_in` input 3: playing FSM state; block is active iff == 3'd4.
- `color_out` output 4: one-hot lit color. Bit0 UP, bit1 RIGHT, bit2 DOWN, bit3 LEFT; 0 = dark.
- `round_out` output 4: current round, 1..ROUNDS; 0 while IDLE and never entered.
- `strike` output 1: one-cycle pulse on a wrong press.
- `clear_edge` output 1: one-cycle pulse on completion.
- `solved` output 1: level, high once completed until MENU.
- `busy` output 1: high in SHOW_OFF/SHOW_ON (input ignored).

## Operation
- Reset values:
  - State IDLE, all outputs 0.
  - `lfsr`=SEED; `seq`=0; `seq_valid`=0; `idx`=0; `timer`=0.
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, shifts left every clk in every state. New bit = b15^b13^b12^b10.
- Color k (0-based) = `seq[2k+1:2k]`. Encoding 0=UP, 1=RIGHT, 2=DOWN, 3=LEFT.
- States:
  - IDLE:
    - On active, go to SHOW_OFF with timer=0 and idx=0.
    - If solved, go to SOLVED instead.
    - If `seq_valid`=0, capture `seq`<=lfsr and set `seq_valid`<=1 on the same edge.
    - Round set to 1 on every non-solved entry.
  - SHOW_OFF:
    - `color_out`=0; timer counts.
    - At timer==GAP_CYCLES-1: if idx<round, go to SHOW_ON; else go to INPUT with idx=0. Timer clears.
  - SHOW_ON:
    - `color_out`=onehot(color idx).
    - At timer==SHOW_CYCLES-1: idx++, go to SHOW_OFF, timer clears.
  - INPUT: acts only on strobe with `button` exactly one of UP/RIGHT/DOWN/LEFT. All other codes are ignored, including SELECT, BACK, NO_PRESS and multi-hot.
    - Correct press, idx+1<round: idx++.
    - Correct press, idx+1==round<ROUNDS: round++, idx=0, go to SHOW_OFF.
    - Correct press, idx+1==round==ROUNDS: go to SOLVED, `solved`<=1, `clear_edge`<=1 for one cycle.
    - Wrong press: `strike`<=1 for one cycle; round=1, idx=0, go to SHOW_OFF.
  - SOLVED: outputs dark, presses ignored. No further `clear_edge` until MENU.
- Deactivation (`playing_state_in`≠4) in any state except IDLE: go to IDLE next edge.
  - idx and timer clear; `color_out` goes 0 that edge.
  - `round_out` holds its value; `seq` and `solved` are kept.
  - A strobe coinciding with deactivation is ignored.
- `game_state_in`==MENU takes priority over everything. Go to IDLE; clear `solved`, `seq_valid`, round, idx and timer.
- No arithmetic overflow: round ≤8 in 4 bits; timer 16 bits compares against parameter−1.

## Timing
- Registered outputs; all changes on posedge clk.
- Entry: active seen at edge E, state SHOW_OFF after E. First color lights GAP_CYCLES cycles later, for SHOW_CYCLES cycles.
- Round r display spans r·(GAP+SHOW)+GAP cycles before INPUT.
- Press response: strobe at edge P, then `strike`/`clear_edge` high for exactly the cycle after P.
- `clear_edge` fires exactly once per MENU-to-MENU session.
- Async reset mid-operation: everything returns to reset values immediately.

## Test plan
- Reset: hold nrst=0 → all outputs 0. Release, keep inactive for 100 cycles → outputs stay 0 while lfsr advances (bench model).
- ROUNDS=2, SHOW=2, GAP=1, enter SIMON:
  - `color_out`=onehot(seq[1:0]) for 2 cycles.
  - Press the correct direction → round_out=2; two colors replay.
  - Both correct → `clear_edge`=1 for one cycle, `solved`=1.
  - Further presses → no pulse.
- Wrong press in round 2 → `strike`=1 for one cycle, round_out=1, replay of 1 color after 1 gap cycle.
- In INPUT, strobe SELECT, BACK, 6'b000110, or NO_PRESS → no state change, no strike.
- Mid-SHOW_ON, set playing_state_in=0 → next cycle `color_out`=0, busy=0. Re-enter → same seq, round_out=1. Solved block re-entered → stays SOLVED, no clear_edge.
- After solve, game_state_in=MENU → solved=0, round_out=0. Re-entry captures a new seq (differs from the first for SEED=16'hACE1 unless equal by chance, checked against the model).
